// File: rtl/apb_uart_rx.sv
// apb_uart_rx: 8N1 UART receiver with RX FIFO behind an APB slave
module apb_uart_rx #(
  parameter int BUS_WIDTH  = 32,
  parameter int DATA_WIDTH = 32,
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 9600,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [BUS_WIDTH-1:0]  S_PADDR,
  input  logic                  S_PWRITE,
  input  logic                  S_PSELx,
  input  logic                  S_PENABLE,
  input  logic [DATA_WIDTH-1:0] S_PWDATA,
  output logic [DATA_WIDTH-1:0] S_PRDATA,
  output logic                  S_PREADY,
  input  logic                  rx_wire,
  output logic                  irq_out,
  output logic [DATA_WIDTH-1:0] irq_data
);
  localparam int CPB = CLK_HZ / BAUD;
  localparam int CW  = $clog2(CPB);
  localparam int AW  = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t        state_q, state_d;
  logic [1:0]    sync_q, vld_q;
  logic [CW-1:0] cc_q, cc_d;
  logic [2:0]    bc_q, bc_d;
  logic [7:0]    sh_q, sh_d;
  logic          armed_q, armed_d, ovr_q, ovr_d, ferr_q, ferr_d;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [AW:0]   cnt_q;
  logic          rx_s, en, wr1, pop, push, push_try, ferr_set, ovr_set, empty, full, unused_ok;
  assign rx_s      = sync_q[1];
  assign en        = S_PSELx & S_PENABLE;
  assign S_PREADY  = en;
  assign wr1       = en & S_PWRITE & S_PADDR[0];
  assign empty     = cnt_q == '0;
  assign full      = cnt_q == (AW+1)'(FIFO_DEPTH);
  assign pop       = en & !S_PWRITE & !S_PADDR[0] & !empty;
  assign push      = push_try & (!full | pop);
  assign ovr_set   = push_try & full & !pop;
  assign irq_out   = !empty;
  assign irq_data  = empty ? '0 : DATA_WIDTH'(mem_q[rp_q]);
  assign S_PRDATA  = (!en || S_PWRITE) ? '0 :
                     S_PADDR[0] ? DATA_WIDTH'({cnt_q, ferr_q, ovr_q, full, !empty}) : irq_data;
  assign ovr_d     = ovr_set | (ovr_q & !(wr1 & S_PWDATA[2]));
  assign ferr_d    = ferr_set | (ferr_q & !(wr1 & S_PWDATA[3]));
  assign unused_ok = ^{S_PADDR, S_PWDATA};
  always_comb begin
    state_d  = state_q;
    cc_d     = cc_q + 1'b1;
    bc_d     = bc_q;
    sh_d     = sh_q;
    armed_d  = armed_q | (rx_s & vld_q[1] & state_q == IDLE);
    push_try = 1'b0;
    ferr_set = 1'b0;
    case (state_q)
      IDLE: begin
        cc_d    = '0;
        state_d = (armed_q && !rx_s) ? START : IDLE;
      end
      START: if (cc_q == CW'(CPB/2-1)) begin
        cc_d    = '0;
        bc_d    = '0;
        state_d = rx_s ? IDLE : DATA;
      end
      DATA: if (cc_q == CW'(CPB-1)) begin
        cc_d       = '0;
        sh_d[bc_q] = rx_s;
        bc_d       = bc_q + 3'd1;
        state_d    = bc_q == 3'd7 ? STOP : DATA;
      end
      default: if (cc_q == CW'(CPB-1)) begin
        cc_d     = '0;
        state_d  = IDLE;
        push_try = rx_s;
        ferr_set = !rx_s;
        armed_d  = rx_s;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      sync_q  <= 2'b11;
      vld_q   <= '0;
      cc_q    <= '0;
      bc_q    <= '0;
      sh_q    <= '0;
      armed_q <= 1'b0;
      ovr_q   <= 1'b0;
      ferr_q  <= 1'b0;
      wp_q    <= '0;
      rp_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sync_q  <= {sync_q[0], rx_wire};
      vld_q   <= {vld_q[0], 1'b1};
      cc_q    <= cc_d;
      bc_q    <= bc_d;
      sh_q    <= sh_d;
      armed_q <= armed_d;
      ovr_q   <= ovr_d;
      ferr_q  <= ferr_d;
      wp_q    <= wp_q + AW'(push);
      rp_q    <= rp_q + AW'(pop);
      cnt_q   <= cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wp_q] <= sh_q;
  end
endmodule

// File: tb/tb_apb_uart_rx.sv
// tb_apb_uart_rx: randomized scoreboard bench for apb_uart_rx
module tb_apb_uart_rx;
  localparam int CPB = 4, DEPTH = 8;
  logic clk = 1'b0, reset = 1'b1, pwrite = 1'b0, psel = 1'b0, penable = 1'b0, rx = 1'b1;
  logic [31:0] paddr = '0, pwdata = '0;
  logic [31:0] prdata, irq_data;
  logic pready, irq;
  int checks = 0, failures = 0;
  logic [31:0] exp_q[$];
  logic [7:0] mq[$];
  bit ovr_m = 0, ferr_m = 0;
  logic [7:0] rb;
  apb_uart_rx #(.BUS_WIDTH(32), .DATA_WIDTH(32), .CLK_HZ(40), .BAUD(10), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .S_PADDR(paddr), .S_PWRITE(pwrite), .S_PSELx(psel),
    .S_PENABLE(penable), .S_PWDATA(pwdata), .S_PRDATA(prdata), .S_PREADY(pready),
    .rx_wire(rx), .irq_out(irq), .irq_data(irq_data)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, want);
    end
  endtask
  task tick;
    @(posedge clk);
    #1;
  endtask
  function automatic logic [31:0] status_m();
    return {23'b0, 5'(mq.size()), ferr_m, ovr_m, mq.size() == DEPTH, mq.size() != 0};
  endfunction
  task automatic apb(input bit wr, input bit a, input logic [31:0] wd);
    if (!wr) begin
      if (a) exp_q.push_back(status_m());
      else if (mq.size() != 0) exp_q.push_back({24'b0, mq.pop_front()});
      else exp_q.push_back(32'h0);
    end else if (a) begin
      if (wd[2]) ovr_m = 0;
      if (wd[3]) ferr_m = 0;
    end
    paddr = {31'b0, a};
    pwrite = wr;
    pwdata = wd;
    psel = 1'b1;
    tick;
    penable = 1'b1;
    tick;
    psel = 1'b0;
    penable = 1'b0;
    pwrite = 1'b0;
  endtask
  task automatic send(input logic [7:0] b, input bit stop, input bit idle = 1, input int nbits = 10);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      rx = bits[i];
      repeat (CPB) tick;
    end
    if (nbits == 10) begin
      rx = idle;
      repeat (3) tick;
      if (!stop) ferr_m = 1;
      else if (mq.size() < DEPTH) mq.push_back(b);
      else ovr_m = 1;
    end
  endtask
  always @(negedge clk) begin
    if (psel && !penable) chk("prdata_idle", prdata, 32'h0);
    if (psel && penable) begin
      chk("pready", {31'b0, pready}, 32'h1);
      if (!pwrite) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL read: unexpected read returned %h", prdata);
        end else chk(paddr[0] ? "status" : "rxdata", prdata, exp_q.pop_front());
      end
    end
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    repeat (3) tick;
    chk("reset_irq", {31'b0, irq}, 32'h0);
    chk("reset_irq_data", irq_data, 32'h0);
    chk("reset_prdata", prdata, 32'h0);
    reset = 1'b0;
    repeat (2) tick;
    apb(0, 1, 0);
    send(8'hA5, 1);
    chk("t1_irq", {31'b0, irq}, 32'h1);
    chk("t1_irq_data", irq_data, 32'h0000_00A5);
    apb(0, 0, 0);
    chk("t1_irq_clr", {31'b0, irq}, 32'h0);
    apb(0, 1, 0);
    for (int i = 1; i <= 9; i++) send(8'(i), 1);
    apb(0, 1, 0);
    for (int i = 0; i < 8; i++) apb(0, 0, 0);
    apb(0, 0, 0);
    apb(1, 1, 32'h4);
    apb(0, 1, 0);
    send(8'h3C, 0, 0);
    repeat (40) tick;
    chk("t3_no_frame", {31'b0, irq}, 32'h0);
    apb(0, 1, 0);
    rx = 1'b1;
    repeat (4) tick;
    send(8'h55, 1);
    apb(0, 1, 0);
    apb(0, 0, 0);
    apb(1, 1, 32'h8);
    apb(0, 1, 0);
    rx = 1'b0;
    tick;
    rx = 1'b1;
    repeat (20) tick;
    chk("t4_glitch", {31'b0, irq}, 32'h0);
    apb(0, 1, 0);
    for (int i = 0; i < 8; i++) send(8'($urandom), 1);
    rb = 8'($urandom);
    fork
      send(rb, 1);
      begin
        repeat (39) tick;
        apb(0, 0, 0);
      end
    join
    apb(0, 1, 0);
    for (int i = 0; i < 8; i++) apb(0, 0, 0);
    send(8'h11, 1);
    send(8'h0F, 1, 1, 5);
    rx = 1'b0;
    tick;
    reset = 1'b1;
    repeat (2) tick;
    reset = 1'b0;
    mq.delete();
    ovr_m = 0;
    ferr_m = 0;
    repeat (8) tick;
    chk("t6_irq", {31'b0, irq}, 32'h0);
    apb(0, 1, 0);
    rx = 1'b1;
    repeat (4) tick;
    send(8'hC3, 1);
    apb(0, 0, 0);
    repeat (14) begin
      send(8'($urandom), $urandom_range(0, 4) != 0);
      repeat ($urandom_range(0, 3)) begin
        case ($urandom_range(0, 2))
          0: apb(0, 0, 0);
          1: apb(0, 1, 0);
          default: apb(1, 1, $urandom);
        endcase
      end
    end
    apb(0, 1, 0);
    while (mq.size() != 0) apb(0, 0, 0);
    apb(0, 1, 0);
    repeat (2) tick;
    chk("scoreboard_drain", 32'(exp_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
